// File: rtl/block_plotter_if.sv
// Bus between the game datapath (master) and block_plotter (slave): rectangle request in,
// one-pixel-per-cycle write stream and status out.
interface block_plotter_if;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [7:0] width;
  logic [6:0] height;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, x_in, y_in, width, height, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, x_in, y_in, width, height, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/block_plotter.sv
// Rasterises one filled, screen-clipped rectangle into single-pixel writes for vga_adapter.
// All outputs are registered; the first pixel appears the cycle after start is accepted.
module block_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic            clk,
  input  logic            reset_n,
  block_plotter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;

  localparam logic [8:0] LP_W = 9'(SCREEN_W);
  localparam logic [7:0] LP_H = 8'(SCREEN_H);

  state_t     r_state, w_state;
  logic [7:0] r_x0, w_x0, r_w, w_w, r_dx, w_dx;
  logic [6:0] r_y0, w_y0, r_h, w_h, r_dy, w_dy;
  logic [2:0] r_col, w_col;
  logic [7:0] r_x, w_x;
  logic [6:0] r_y, w_y;
  logic [2:0] r_colour, w_colour;
  logic       r_plot, w_plot, r_busy, w_busy, r_done, w_done;
  logic       w_present, w_last_col, w_last_row;
  logic [8:0] w_sx;
  logic [7:0] w_sy;

  assign w_last_col = (r_dx == r_w - 8'd1);
  assign w_last_row = (r_dy == r_h - 7'd1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state   = r_state;
    w_x0      = r_x0;
    w_y0      = r_y0;
    w_w       = r_w;
    w_h       = r_h;
    w_col     = r_col;
    w_dx      = r_dx;
    w_dy      = r_dy;
    w_present = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_x0  = bus.x_in;
          w_y0  = bus.y_in;
          w_w   = bus.width;
          w_h   = bus.height;
          w_col = bus.colour_in;
          w_dx  = '0;
          w_dy  = '0;
          if (bus.width == 8'd0 || bus.height == 7'd0) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_state   = ST_DRAW;
            w_present = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        if (w_last_col && w_last_row) begin
          w_state = ST_DONE;
          w_done  = 1'b1;
        end else if (w_last_col) begin
          w_dx      = '0;
          w_dy      = r_dy + 7'd1;
          w_present = 1'b1;
        end else begin
          w_dx      = r_dx + 8'd1;
          w_present = 1'b1;
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase

    // Widened sums so off-screen coordinates are detected rather than wrapped.
    w_sx     = {1'b0, w_x0} + {1'b0, w_dx};
    w_sy     = {1'b0, w_y0} + {1'b0, w_dy};
    w_x      = w_present ? w_sx[7:0] : r_x;
    w_y      = w_present ? w_sy[6:0] : r_y;
    w_colour = w_present ? w_col     : r_colour;
    w_plot   = w_present && (w_sx < LP_W) && (w_sy < LP_H);
    w_busy   = w_present;
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding update-order races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_x0     <= w_x0;
      r_y0     <= w_y0;
      r_w      <= w_w;
      r_h      <= w_h;
      r_col    <= w_col;
      r_dx     <= w_dx;
      r_dy     <= w_dy;
      r_x      <= w_x;
      r_y      <= w_y;
      r_colour <= w_colour;
      r_plot   <= w_plot;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_block_plotter.sv
// Directed bench for block_plotter: hand-computed pixel streams, clipping, ignored starts,
// mid-draw reset, full-screen clear and start-held retrigger.
module tb_block_plotter;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  block_plotter_if bus ();

  block_plotter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input logic p, input logic [7:0] ex, input logic [6:0] ey,
                     input logic [2:0] ec, input logic eb, input logic ed);
    check({tag, ".plot"},   16'(bus.plot),   16'(p));
    check({tag, ".x"},      16'(bus.x),      16'(ex));
    check({tag, ".y"},      16'(bus.y),      16'(ey));
    check({tag, ".colour"}, 16'(bus.colour), 16'(ec));
    check({tag, ".busy"},   16'(bus.busy),   16'(eb));
    check({tag, ".done"},   16'(bus.done),   16'(ed));
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] rx, input logic [6:0] ry, input logic [7:0] rw,
                         input logic [6:0] rh, input logic [2:0] rc);
    bus.x_in      = rx;
    bus.y_in      = ry;
    bus.width     = rw;
    bus.height    = rh;
    bus.colour_in = rc;
    bus.start     = 1'b1;
  endtask

  initial begin
    int errs;
    int plots;
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.width     = '0;
    bus.height    = '0;
    bus.colour_in = '0;

    // Reset state
    #1;
    pix("reset", 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    pix("idle_after_reset", 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);

    // 1: 2x2 at (10,20), colour 100
    request(8'd10, 7'd20, 8'd2, 7'd2, 3'b100);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix($sformatf("t1_px%0d", i), 1'b1, 8'(10 + i % 2), 7'(20 + i / 2), 3'b100, 1'b1, 1'b0);
      step();
    end
    pix("t1_done", 1'b0, 8'd11, 7'd21, 3'b100, 1'b0, 1'b1);
    step();
    pix("t1_idle_hold", 1'b0, 8'd11, 7'd21, 3'b100, 1'b0, 1'b0);

    // 2: empty rectangle, width 0
    request(8'd50, 7'd50, 8'd0, 7'd5, 3'b010);
    step();
    bus.start = 1'b0;
    pix("t2_done", 1'b0, 8'd11, 7'd21, 3'b100, 1'b0, 1'b1);
    step();
    pix("t2_idle", 1'b0, 8'd11, 7'd21, 3'b100, 1'b0, 1'b0);

    // 3: clipping at the bottom-right corner
    request(8'd158, 7'd119, 8'd4, 7'd2, 3'b011);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pix($sformatf("t3_px%0d", i), (i == 0 || i == 1), 8'(158 + i % 4), 7'(119 + i / 4),
          3'b011, 1'b1, 1'b0);
      step();
    end
    check("t3_done", 16'(bus.done), 16'd1);
    check("t3_done_plot", 16'(bus.plot), 16'd0);

    // 4: start pulsed mid-draw with a different colour is ignored
    step();
    request(8'd5, 7'd6, 8'd3, 7'd1, 3'b010);
    step();
    bus.start = 1'b0;
    pix("t4_px0", 1'b1, 8'd5, 7'd6, 3'b010, 1'b1, 1'b0);
    request(8'd90, 7'd90, 8'd1, 7'd1, 3'b111);
    step();
    bus.start = 1'b0;
    pix("t4_px1", 1'b1, 8'd6, 7'd6, 3'b010, 1'b1, 1'b0);
    step();
    pix("t4_px2", 1'b1, 8'd7, 7'd6, 3'b010, 1'b1, 1'b0);
    step();
    pix("t4_done", 1'b0, 8'd7, 7'd6, 3'b010, 1'b0, 1'b1);
    plots = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.plot === 1'b1) plots++;
    end
    check("t4_no_queued_plots", 16'(plots), 16'd0);

    // 5: reset in the middle of a 4x4 draw
    request(8'd30, 7'd40, 8'd4, 7'd4, 3'b101);
    step();
    bus.start = 1'b0;
    pix("t5_px0", 1'b1, 8'd30, 7'd40, 3'b101, 1'b1, 1'b0);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    pix("t5_reset", 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    plots = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.plot !== 1'b0 || bus.busy !== 1'b0) plots++;
    end
    check("t5_quiet_after_release", 16'(plots), 16'd0);

    // 6: full-screen clear in raster order
    request(8'd0, 7'd0, 8'd160, 7'd120, 3'b000);
    step();
    bus.start = 1'b0;
    errs = 0;
    plots = 0;
    for (int i = 0; i < 19200; i++) begin
      if (bus.plot === 1'b1) plots++;
      if (bus.x !== 8'(i % 160) || bus.y !== 7'(i / 160) || bus.busy !== 1'b1) errs++;
      if (i == 19199) pix("t6_last", 1'b1, 8'd159, 7'd119, 3'd0, 1'b1, 1'b0);
      step();
    end
    check("t6_raster_errors", 16'(errs), 16'd0);
    check("t6_plot_count", 16'(plots), 16'd19200);
    pix("t6_done", 1'b0, 8'd159, 7'd119, 3'd0, 1'b0, 1'b1);
    step();

    // 7: start held high retriggers with a two-cycle gap after done
    request(8'd1, 7'd2, 8'd1, 7'd1, 3'b110);
    step();
    pix("t7_px_a", 1'b1, 8'd1, 7'd2, 3'b110, 1'b1, 1'b0);
    step();
    pix("t7_done", 1'b0, 8'd1, 7'd2, 3'b110, 1'b0, 1'b1);
    step();
    pix("t7_gap", 1'b0, 8'd1, 7'd2, 3'b110, 1'b0, 1'b0);
    step();
    pix("t7_px_b", 1'b1, 8'd1, 7'd2, 3'b110, 1'b1, 1'b0);
    bus.start = 1'b0;
    step();
    check("t7_done_b", 16'(bus.done), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
